// File: rtl/lfsr_period_meter.sv
// ---------------------------------------------------------------------------
// lfsr_period_meter
//   Watches the state word of a Galois LFSR generator and measures how many
//   advancing steps it takes for the captured start state to reappear.
//   Flags maximal-length sequences, the all-zero lock-up state and sequences
//   that never return to their start state (timeout).
//
// Ports
//   CLK_I      in   1          clock, rising edge
//   RST_N_I    in   1          asynchronous active-low reset
//   START_I    in   1          one-cycle pulse: clear results, arm a measurement
//   VALID_I    in   1          DATA_I carries a new generator state this cycle
//   DATA_I     in   MAX_LEN    generator state word
//   BUSY_O     out  1          measurement armed or counting
//   DONE_O     out  1          one-cycle completion pulse
//   PERIOD_O   out  MAX_LEN+1  measured period (0 on timeout)
//   MAXLEN_O   out  1          period equals 2^MAX_LEN-1
//   LOCKUP_O   out  1          captured start state was all-zero
//   TIMEOUT_O  out  1          no recurrence within 2^MAX_LEN steps
//
// All outputs come straight from flops; nothing on the input side reaches an
// output combinationally.
// ---------------------------------------------------------------------------
module lfsr_period_meter #(
  parameter int MAX_LEN = 8
) (
  input  logic               CLK_I,
  input  logic               RST_N_I,
  input  logic               START_I,
  input  logic               VALID_I,
  input  logic [MAX_LEN-1:0] DATA_I,
  output logic               BUSY_O,
  output logic               DONE_O,
  output logic [MAX_LEN:0]   PERIOD_O,
  output logic               MAXLEN_O,
  output logic               LOCKUP_O,
  output logic               TIMEOUT_O
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // 2^MAX_LEN: step count at which a non-recurring sequence is abandoned.
  localparam logic [MAX_LEN:0] TIMEOUT_STEPS_C = {1'b1, {MAX_LEN{1'b0}}};
  // 2^MAX_LEN-1: period of a maximal-length sequence.
  localparam logic [MAX_LEN:0] MAX_PERIOD_C    = {1'b0, {MAX_LEN{1'b1}}};
  localparam logic [MAX_LEN:0] ONE_C           = {{MAX_LEN{1'b0}}, 1'b1};
  localparam logic [MAX_LEN:0] ZERO_C          = {(MAX_LEN+1){1'b0}};
  localparam logic [MAX_LEN-1:0] DATA_ZERO_C   = {MAX_LEN{1'b0}};

  state_t               state_r,   state_s;
  logic [MAX_LEN-1:0]   ref_r,     ref_s;
  logic [MAX_LEN:0]     cnt_r,     cnt_s;
  logic [MAX_LEN:0]     period_r,  period_s;
  logic                 maxlen_r,  maxlen_s;
  logic                 lockup_r,  lockup_s;
  logic                 timeout_r, timeout_s;
  logic                 done_r,    done_s;
  logic                 busy_r,    busy_s;
  logic [MAX_LEN:0]     step_s;

  // Next-state and next-result logic for the measurement FSM.
  always_comb begin
    state_s   = state_r;
    ref_s     = ref_r;
    cnt_s     = cnt_r;
    period_s  = period_r;
    maxlen_s  = maxlen_r;
    lockup_s  = lockup_r;
    timeout_s = timeout_r;
    done_s    = 1'b0;
    // cnt never exceeds 2^MAX_LEN-1 here, so the increment cannot overflow.
    step_s    = cnt_r + ONE_C;

    if (START_I && (state_r != IDLE)) begin
      // START wins over everything, including a coincident VALID sample.
      state_s   = ARM;
      ref_s     = DATA_ZERO_C;
      cnt_s     = ZERO_C;
      period_s  = ZERO_C;
      maxlen_s  = 1'b0;
      lockup_s  = 1'b0;
      timeout_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (START_I) begin
            state_s = ARM;
          end else begin
            state_s = IDLE;
          end
        end

        ARM: begin
          if (VALID_I) begin
            ref_s = DATA_I;
            cnt_s = ZERO_C;
            if (DATA_I == DATA_ZERO_C) begin
              // Zero is a fixed point of the LFSR: period 1, never maximal.
              state_s  = DONE;
              lockup_s = 1'b1;
              period_s = ONE_C;
              maxlen_s = 1'b0;
              done_s   = 1'b1;
            end else begin
              state_s = COUNT;
            end
          end else begin
            state_s = ARM;
          end
        end

        COUNT: begin
          if (VALID_I) begin
            if (DATA_I == ref_r) begin
              state_s  = DONE;
              period_s = step_s;
              maxlen_s = (step_s == MAX_PERIOD_C);
              done_s   = 1'b1;
            end else if (step_s == TIMEOUT_STEPS_C) begin
              state_s   = DONE;
              timeout_s = 1'b1;
              period_s  = ZERO_C;
              maxlen_s  = 1'b0;
              done_s    = 1'b1;
            end else begin
              cnt_s = step_s;
            end
          end else begin
            state_s = COUNT;
          end
        end

        DONE: begin
          state_s = DONE;
        end

        default: begin
          state_s   = IDLE;
          ref_s     = DATA_ZERO_C;
          cnt_s     = ZERO_C;
          period_s  = ZERO_C;
          maxlen_s  = 1'b0;
          lockup_s  = 1'b0;
          timeout_s = 1'b0;
        end
      endcase
    end

    // BUSY is registered, so it is derived from the state being entered.
    busy_s = (state_s == ARM) || (state_s == COUNT);
  end

  // State, reference, counter and result registers.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_r   <= IDLE;
      ref_r     <= DATA_ZERO_C;
      cnt_r     <= ZERO_C;
      period_r  <= ZERO_C;
      maxlen_r  <= 1'b0;
      lockup_r  <= 1'b0;
      timeout_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      ref_r     <= ref_s;
      cnt_r     <= cnt_s;
      period_r  <= period_s;
      maxlen_r  <= maxlen_s;
      lockup_r  <= lockup_s;
      timeout_r <= timeout_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
    end
  end

  assign BUSY_O    = busy_r;
  assign DONE_O    = done_r;
  assign PERIOD_O  = period_r;
  assign MAXLEN_O  = maxlen_r;
  assign LOCKUP_O  = lockup_r;
  assign TIMEOUT_O = timeout_r;

endmodule

// File: tb/tb_lfsr_period_meter.sv
// ---------------------------------------------------------------------------
// tb_lfsr_period_meter
//   Directed bench for lfsr_period_meter at MAX_LEN=4. A reference model
//   keeps the list of samples seen since the last START and derives the
//   results from that list; the DUT outputs are compared against it on every
//   falling edge, and a few hand-computed values pin the model itself.
// ---------------------------------------------------------------------------
module tb_lfsr_period_meter;

  localparam int MW = 4;

  logic          CLK_I   = 1'b0;
  logic          RST_N_I = 1'b0;
  logic          START_I = 1'b0;
  logic          VALID_I = 1'b0;
  logic [MW-1:0] DATA_I  = '0;
  logic          BUSY_O;
  logic          DONE_O;
  logic [MW:0]   PERIOD_O;
  logic          MAXLEN_O;
  logic          LOCKUP_O;
  logic          TIMEOUT_O;

  lfsr_period_meter #(.MAX_LEN(MW)) dut (
    .CLK_I     (CLK_I),
    .RST_N_I   (RST_N_I),
    .START_I   (START_I),
    .VALID_I   (VALID_I),
    .DATA_I    (DATA_I),
    .BUSY_O    (BUSY_O),
    .DONE_O    (DONE_O),
    .PERIOD_O  (PERIOD_O),
    .MAXLEN_O  (MAXLEN_O),
    .LOCKUP_O  (LOCKUP_O),
    .TIMEOUT_O (TIMEOUT_O)
  );

  always #5 CLK_I = ~CLK_I;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [MW-1:0] seq[$];
  bit started  = 1'b0;
  bit finished = 1'b0;
  int exp_period  = 0;
  bit exp_maxlen  = 1'b0;
  bit exp_lockup  = 1'b0;
  bit exp_timeout = 1'b0;
  bit exp_done    = 1'b0;

  task automatic model_clear();
    seq.delete();
    finished    = 1'b0;
    exp_period  = 0;
    exp_maxlen  = 1'b0;
    exp_lockup  = 1'b0;
    exp_timeout = 1'b0;
    exp_done    = 1'b0;
  endtask

  task automatic model_clock();
    int n;
    exp_done = 1'b0;
    if (START_I) begin
      model_clear();
      started = 1'b1;
    end else if (started && !finished && VALID_I) begin
      seq.push_back(DATA_I);
      n = seq.size();
      if (n == 1) begin
        if (seq[0] == '0) begin
          finished = 1'b1; exp_done = 1'b1; exp_lockup = 1'b1; exp_period = 1;
        end
      end else if (seq[n-1] == seq[0]) begin
        finished = 1'b1; exp_done = 1'b1; exp_period = n - 1;
        exp_maxlen = ((n - 1) == ((1 << MW) - 1));
      end else if ((n - 1) == (1 << MW)) begin
        finished = 1'b1; exp_done = 1'b1; exp_timeout = 1'b1; exp_period = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK_I or negedge RST_N_I);
      if (!RST_N_I) begin
        model_clear();
        started = 1'b0;
      end else begin
        model_clock();
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK_I);
      chk("busy",    int'(BUSY_O),    int'(started && !finished));
      chk("done",    int'(DONE_O),    int'(exp_done));
      chk("period",  int'(PERIOD_O),  exp_period);
      chk("maxlen",  int'(MAXLEN_O),  int'(exp_maxlen));
      chk("lockup",  int'(LOCKUP_O),  int'(exp_lockup));
      chk("timeout", int'(TIMEOUT_O), int'(exp_timeout));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit v, input logic [MW-1:0] d);
    @(negedge CLK_I);
    START_I = s;
    VALID_I = v;
    DATA_I  = d;
  endtask

  task automatic pin(input int p, input bit mx, input bit lk, input bit to);
    // Called right after the cycle that follows the terminating sample.
    #1;
    chk("pin_done",    int'(DONE_O),    1);
    chk("pin_period",  int'(PERIOD_O),  p);
    chk("pin_maxlen",  int'(MAXLEN_O),  int'(mx));
    chk("pin_lockup",  int'(LOCKUP_O),  int'(lk));
    chk("pin_timeout", int'(TIMEOUT_O), int'(to));
  endtask

  initial begin
    logic [MW-1:0] pat2 [7];
    pat2 = '{4'd9, 4'd4, 4'd2, 4'd1, 4'd8, 4'd12, 4'd9};

    #23 RST_N_I = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // Counting sequence 1..15 then 1: period 15, maximal.
    step(1, 0, 0);
    for (int i = 1; i <= 15; i++) step(0, 1, 4'(i));
    step(0, 1, 4'd1);
    step(0, 0, 0);
    pin(15, 1'b1, 1'b0, 1'b0);
    step(0, 0, 0);

    // Period-6 sequence with VALID toggling; data during gaps equals ref.
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, pat2[i]);
      step(0, 0, 4'd9);
    end
    pin(6, 1'b0, 1'b0, 1'b0);

    // START coincident with a sample (not captured), then zero -> lock-up.
    step(1, 1, 4'd5);
    step(0, 1, 4'd0);
    step(0, 0, 0);
    pin(1, 1'b0, 1'b1, 1'b0);

    // ref=5 then sixteen 3s: timeout after the 16th.
    step(1, 0, 0);
    step(0, 1, 4'd5);
    for (int i = 0; i < 16; i++) step(0, 1, 4'd3);
    step(0, 0, 0);
    pin(0, 1'b0, 1'b0, 1'b1);

    // Abort after 7 counted samples, then period-4 sequence.
    step(1, 0, 0);
    for (int i = 1; i <= 8; i++) step(0, 1, 4'(i));
    step(1, 0, 0);
    step(0, 1, 4'd3);
    step(0, 1, 4'd6);
    step(0, 1, 4'd12);
    step(0, 1, 4'd7);
    step(0, 1, 4'd3);
    step(0, 0, 0);
    pin(4, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a count.
    step(1, 0, 0);
    step(0, 1, 4'd1);
    step(0, 1, 4'd2);
    step(0, 1, 4'd3);
    @(posedge CLK_I);
    #2 RST_N_I = 1'b0;
    #1;
    chk("rst_busy",   int'(BUSY_O),   0);
    chk("rst_done",   int'(DONE_O),   0);
    chk("rst_period", int'(PERIOD_O), 0);
    VALID_I = 1'b0;
    DATA_I  = '0;
    step(0, 0, 0);
    step(0, 0, 0);
    #2 RST_N_I = 1'b1;

    // Clean measurement after reset: period 3.
    step(1, 0, 0);
    step(0, 1, 4'd5);
    step(0, 1, 4'd7);
    step(0, 1, 4'd9);
    step(0, 1, 4'd5);
    step(0, 0, 0);
    pin(3, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0);
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
